// File: rtl/reg_file.sv
// 32-entry MIPS general-purpose register file: $zero hardwired, $sp reset to SP_INIT,
// two combinational read ports plus a debug port. Optional macro: REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int unsigned           WIDTH   = 32,
  parameter int unsigned           DEPTH   = 32,
  parameter logic [WIDTH-1:0]      SP_INIT = 32'h0000_3FFC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  logic [4:0]       w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [4:0]       r_addr1,
  input  logic [4:0]       r_addr2,
  output logic [WIDTH-1:0] r_data1,
  output logic [WIDTH-1:0] r_data2,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0] we_s;
  logic [WIDTH-1:0] arr1_s;
  logic [WIDTH-1:0] arr2_s;

  // Array read: index 0 and out-of-range indices read as zero.
  function automatic logic [WIDTH-1:0] rd_arr(input logic [4:0] addr,
                                              input logic [WIDTH-1:0] arr [DEPTH]);
    logic [WIDTH-1:0] val;
    val = {WIDTH{1'b0}};
    if ((addr != 5'd0) && (32'(addr) < DEPTH)) begin
      val = arr[addr];
    end else begin
      val = {WIDTH{1'b0}};
    end
    return val;
  endfunction

  // Per-entry write decode; an unknown w_addr leaves every enable non-true.
  always_comb begin
    we_s = {DEPTH{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      we_s[i] = reg_write && (w_addr == 5'(i));
    end
  end

  // Storage array with synchronous reset taking priority over writes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        regs_r[i] <= (i == 29) ? SP_INIT : {WIDTH{1'b0}};
      end else if (we_s[i]) begin
        regs_r[i] <= w_data;
      end else begin
        regs_r[i] <= regs_r[i];
      end
    end
  end

  assign arr1_s   = rd_arr(r_addr1, regs_r);
  assign arr2_s   = rd_arr(r_addr2, regs_r);
  assign dbg_data = rd_arr(dbg_addr, regs_r);

`ifdef REG_FILE_BYPASS_EN
  logic fwd1_s;
  logic fwd2_s;

  // Write-first forwarding removes the WB->ID hazard; suppressed during reset.
  always_comb begin
    fwd1_s = !rst && reg_write && (w_addr != 5'd0) && (r_addr1 == w_addr);
    fwd2_s = !rst && reg_write && (w_addr != 5'd0) && (r_addr2 == w_addr);
    if (fwd1_s) begin
      r_data1 = w_data;
    end else begin
      r_data1 = arr1_s;
    end
    if (fwd2_s) begin
      r_data2 = w_data;
    end else begin
      r_data2 = arr2_s;
    end
  end
`else
  assign r_data1 = arr1_s;
  assign r_data2 = arr2_s;
`endif

endmodule
